// File: rtl/sica_pkg.sv
// Shared definitions for the sica stream controller: FSM encoding, window size helper
// and the default RUN timeout shared with the system-level bench.
package sica_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_RUN   = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    localparam int DEFAULT_TIMEOUT = 1000000;

    function automatic int n_words(input int dim, input int samples);
        return dim * samples;
    endfunction

endpackage

// File: rtl/sica_result_serializer.sv
// Captures the full s_est bus once per window and replays it word by word
// over a registered valid/ready output, word 0 first.
module sica_result_serializer
    import sica_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DIM        = 5,
    parameter int SAMPLES    = 10,
    parameter int CNT_W      = $clog2(DIM*SAMPLES+1)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                capture,
    input  logic                                start_drain,
    input  logic [DATA_WIDTH*DIM*SAMPLES-1:0]   s_est,
    output logic signed [DATA_WIDTH-1:0]        out_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic                                drain_done
);

    localparam int N_WORDS = n_words(DIM, SAMPLES);

    logic [DATA_WIDTH*N_WORDS-1:0] cap;
    logic [CNT_W-1:0]              rc;
    logic [CNT_W-1:0]              rc_next;
    logic                          accept;

    assign accept     = out_valid && out_ready;
    assign drain_done = accept && (rc == CNT_W'(N_WORDS - 1));
    assign rc_next    = rc + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            cap       <= '0;
            rc        <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (capture) begin
                cap <= s_est;
            end
            // The first word bypasses cap when capture and start_drain coincide.
            if (start_drain) begin
                rc        <= '0;
                out_valid <= 1'b1;
                out_data  <= capture ? s_est[0 +: DATA_WIDTH] : cap[0 +: DATA_WIDTH];
            end else if (drain_done) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                rc       <= rc_next;
                out_data <= cap[int'(rc_next)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/sica_stream_ctrl.sv
// Window sequencer for sica_top: streams input words into the serial load port,
// pulses start, waits for completion under a timeout, then drains the results.
module sica_stream_ctrl
    import sica_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int DIM            = 5,
    parameter int SAMPLES        = 10,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
    parameter int CNT_W          = $clog2(DIM*SAMPLES+1),
    parameter int TO_W           = $clog2(TIMEOUT_CYCLES+1)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                go,
    input  logic signed [DATA_WIDTH-1:0]        in_data,
    input  logic                                in_valid,
    output logic                                in_ready,
    output logic signed [DATA_WIDTH-1:0]        z_out,
    output logic                                z_valid_out,
    output logic                                load_data_out,
    output logic                                sica_start_out,
    input  logic                                sica_complete_in,
    input  logic [DATA_WIDTH*DIM*SAMPLES-1:0]   s_est_in,
    output logic signed [DATA_WIDTH-1:0]        out_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic                                busy,
    output logic                                timeout_err
);

    localparam int N_WORDS = n_words(DIM, SAMPLES);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] wc;
    logic [TO_W-1:0]  tc;
    logic             accept_in;
    logic             all_loaded;
    logic             capture;
    logic             run_timeout;
    logic             drain_done;

    // wc reaching N_WORDS keeps LOAD alive one extra cycle so the last z word
    // is still framed by load_data_out and the start pulse follows it.
    assign all_loaded  = (wc == CNT_W'(N_WORDS));
    assign accept_in   = in_valid && in_ready;
    assign capture     = (state == ST_RUN) && sica_complete_in;
    assign run_timeout = (state == ST_RUN) && !sica_complete_in
                         && (tc == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:  if (go)          state_next = ST_LOAD;
            ST_LOAD:  if (all_loaded)  state_next = ST_START;
            ST_START:                  state_next = ST_RUN;
            ST_RUN: begin
                if (capture)           state_next = ST_DRAIN;
                else if (run_timeout)  state_next = ST_IDLE;
            end
            ST_DRAIN: if (drain_done)  state_next = ST_IDLE;
            default:                   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready       = (state == ST_LOAD) && !all_loaded;
        load_data_out  = (state == ST_LOAD);
        sica_start_out = (state == ST_START);
        busy           = (state != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wc          <= '0;
            tc          <= '0;
            timeout_err <= 1'b0;
            z_out       <= '0;
            z_valid_out <= 1'b0;
        end else begin
            z_valid_out <= accept_in;
            if (accept_in) begin
                z_out <= in_data;
            end
            if ((state == ST_IDLE) && go) begin
                wc          <= '0;
                timeout_err <= 1'b0;
            end else if (accept_in) begin
                wc <= wc + CNT_W'(1);
            end
            if (state == ST_START) begin
                tc <= '0;
            end else if ((state == ST_RUN) && !capture && !run_timeout) begin
                tc <= tc + TO_W'(1);
            end
            if (run_timeout) begin
                timeout_err <= 1'b1;
            end
        end
    end

    sica_result_serializer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DIM        (DIM),
        .SAMPLES    (SAMPLES),
        .CNT_W      (CNT_W)
    ) u_serializer (
        .clk         (clk),
        .reset       (reset),
        .capture     (capture),
        .start_drain (capture),
        .s_est       (s_est_in),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .drain_done  (drain_done)
    );

endmodule

// File: tb/tb_sica_stream_ctrl.sv
// Directed-sequence bench for sica_stream_ctrl with randomized words, bubbles and
// back-pressure, checked against a window-level model of expected word streams.
module tb_sica_stream_ctrl;

    localparam int W  = 32;
    localparam int N  = 50;
    localparam int TO = 250;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 go;
    logic signed [W-1:0]  in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [W-1:0]  z_out;
    logic                 z_valid_out;
    logic                 load_data_out;
    logic                 sica_start_out;
    logic                 sica_complete_in;
    logic [W*N-1:0]       s_est_in;
    logic signed [W-1:0]  out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 busy;
    logic                 timeout_err;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int exp_starts = 0;
    logic signed [W-1:0] win [N];
    logic signed [W-1:0] est [N];

    sica_stream_ctrl #(
        .DATA_WIDTH     (W),
        .DIM            (5),
        .SAMPLES        (10),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .go               (go),
        .in_data          (in_data),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .z_out            (z_out),
        .z_valid_out      (z_valid_out),
        .load_data_out    (load_data_out),
        .sica_start_out   (sica_start_out),
        .sica_complete_in (sica_complete_in),
        .s_est_in         (s_est_in),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .busy             (busy),
        .timeout_err      (timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sica_start_out === 1'b1) start_cnt <= start_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_z_out"}, z_out, 0);
        chk({tag, "_z_valid"}, z_valid_out, 0);
        chk({tag, "_load_data"}, load_data_out, 0);
        chk({tag, "_start"}, sica_start_out, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_timeout_err"}, timeout_err, 0);
    endtask

    task automatic fill_window(input int wmode, input int emode);
        for (int k = 0; k < N; k++) begin
            win[k] = (wmode == 0) ? W'(k + 1) : W'($urandom);
            est[k] = (emode == 0) ? -W'(k) : W'($urandom);
            s_est_in[k*W +: W] = est[k];
        end
    endtask

    task automatic start_window();
        chk("idle_busy", busy, 0);
        go = 1'b1;
        step();
        go = 1'b0;
        chk("go_busy", busy, 1);
        chk("go_clears_err", timeout_err, 0);
    endtask

    // mode 0: back-to-back, 1: valid pattern 1,0,0, 2: random valid
    task automatic load_phase(input int mode, input int abort_at, output bit aborted);
        int idx = 0;
        int cyc = 0;
        bit v;
        aborted = 1'b0;
        while (idx < N && cyc < 2000) begin
            chk("in_ready", in_ready, 1);
            chk("load_data", load_data_out, 1);
            if (idx == abort_at) begin
                reset = 1'b1;
                in_valid = 1'b1;
                in_data = win[idx];
                step();
                reset = 1'b0;
                in_valid = 1'b0;
                aborted = 1'b1;
                return;
            end
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 3 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            in_valid = v;
            in_data = v ? win[idx] : W'($urandom);
            step();
            cyc++;
            chk("z_valid", z_valid_out, v);
            if (v) begin
                chk("z_out", z_out, win[idx]);
                idx++;
            end else if (idx > 0) begin
                chk("z_out_hold", z_out, win[idx-1]);
            end
        end
        if (idx < N) chk("load_bound", idx, N);
        chk("load_last_frame", load_data_out, 1);
        chk("ready_drop", in_ready, 0);
        in_valid = 1'b1;
        in_data = 32'h5151_5151;
        step();
        in_valid = 1'b0;
        chk("start_pulse", sica_start_out, 1);
        chk("load_fall", load_data_out, 0);
        chk("no_51st", z_valid_out, 0);
        chk("z_out_last", z_out, win[N-1]);
        chk("start_ready", in_ready, 0);
    endtask

    // smode 0: always ready, 1: stall 3 cycles at word 7, 2: random ready
    task automatic run_phase(input int d, input bit tmo, input int smode, input bit go_last);
        int idx = 0;
        int cyc = 0;
        int stalls = 0;
        bit r;
        step();
        chk("start_once", sica_start_out, 0);
        chk("start_cnt", start_cnt, exp_starts);
        if (tmo) begin
            for (int i = 0; i < TO; i++) begin
                chk("run_err", timeout_err, 0);
                chk("run_busy", busy, 1);
                chk("run_no_out", out_valid, 0);
                step();
            end
            chk("timeout_err", timeout_err, 1);
            chk("timeout_idle", busy, 0);
            chk("timeout_no_out", out_valid, 0);
            return;
        end
        for (int i = 0; i < d; i++) begin
            chk("wait_no_out", out_valid, 0);
            chk("wait_busy", busy, 1);
            step();
        end
        sica_complete_in = 1'b1;
        step();
        sica_complete_in = 1'b0;
        while (idx < N && cyc < 2000) begin
            chk("out_valid", out_valid, 1);
            chk("out_data", out_data, est[idx]);
            chk("drain_busy", busy, 1);
            case (smode)
                0:       r = 1'b1;
                1:       r = !(idx == 7 && stalls < 3);
                default: r = 1'($urandom_range(0, 1));
            endcase
            if (!r) stalls++;
            out_ready = r;
            go = go_last && r && (idx == N - 1);
            step();
            cyc++;
            go = 1'b0;
            if (r) idx++;
        end
        if (idx < N) chk("drain_bound", idx, N);
        out_ready = 1'b0;
        chk("drain_end_valid", out_valid, 0);
        chk("drain_end_busy", busy, 0);
        step();
        chk("late_go_ignored", busy, 0);
        chk("late_go_ready", in_ready, 0);
        chk("start_total", start_cnt, exp_starts);
    endtask

    task automatic run_window(input int wmode, input int emode, input int lmode,
                              input int d, input bit tmo, input int smode, input bit go_last);
        bit ab;
        fill_window(wmode, emode);
        start_window();
        load_phase(lmode, -1, ab);
        exp_starts++;
        run_phase(d, tmo, smode, go_last);
    endtask

    initial begin
        bit ab;
        reset = 1'b1;
        go = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        sica_complete_in = 1'b0;
        s_est_in = '0;
        out_ready = 1'b0;
        step();
        step();
        check_all_zero("reset");
        reset = 1'b0;
        step();
        check_all_zero("post_reset");

        run_window(0, 0, 0, 200, 1'b0, 0, 1'b1);
        run_window(1, 0, 1, 200, 1'b0, 1, 1'b0);
        run_window(1, 1, 2, $urandom_range(0, TO - 10), 1'b0, 2, 1'b0);

        run_window(1, 1, 2, 0, 1'b1, 0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("err_sticky", timeout_err, 1);
            chk("err_idle", busy, 0);
        end

        fill_window(1, 1);
        start_window();
        load_phase(0, 23, ab);
        chk("aborted", ab, 1);
        check_all_zero("abort");
        for (int i = 0; i < 5; i++) begin
            step();
            chk("abort_idle", busy, 0);
            chk("abort_no_start", start_cnt, exp_starts);
        end

        run_window(1, 1, 2, $urandom_range(0, 50), 1'b0, 2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sica_stream_ctrl.md
Name: sica_stream_ctrl

Overview:
Sequencing front/back end for sica_top. It accepts a channel-major stream of DIM*SAMPLES whitened words over a valid/ready handshake and drives sica_top's serial load interface. It then issues the start pulse and waits for completion, with a cycle timeout. Finally it captures the s_est bus and drains it as a valid/ready word stream. This lets a host DMA or UART bridge run successive windows without hand-timed stimulus.

Parameters:
- DATA_WIDTH, 32, word width, matches sica_top.
- DIM, 5, number of channels.
- SAMPLES, 10, samples per channel per window.
- TIMEOUT_CYCLES, 1000000, maximum cycles allowed in RUN before abort.
- CNT_W, $clog2(DIM*SAMPLES+1), word counter width.
- TO_W, $clog2(TIMEOUT_CYCLES+1), timeout counter width.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- go  in  1  single-cycle window request; honoured only in IDLE.
- in_data  in  DATA_WIDTH  signed input word, channel-major (ch0 s0..sS-1, ch1 ...).
- in_valid  in  1  in_data valid.
- in_ready  out  1  high only in LOAD.
- z_out  out  DATA_WIDTH  to sica_top serial_z_in.
- z_valid_out  out  1  to sica_top serial_z_valid.
- load_data_out  out  1  to sica_top load_data.
- sica_start_out  out  1  to sica_top sica_start.
- sica_complete_in  in  1  from sica_top sica_complete.
- s_est_in  in  DATA_WIDTH*DIM*SAMPLES  from sica_top s_est.
- out_data  out  DATA_WIDTH  separated-source word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accept.
- busy  out  1  state != IDLE.
- timeout_err  out  1  sticky; set on timeout; cleared by reset or an accepted go.

Behaviour:
- Reset (synchronous, active-high): state=IDLE. All outputs 0, including z_out, out_data, counters and the capture register. Reset mid-operation aborts immediately; no further sica_start pulse is issued.
- States: IDLE, LOAD, START, RUN, DRAIN.
- Total word count N = DIM*SAMPLES.
- IDLE:
  - go=1 -> LOAD; word counter wc=0; timeout_err cleared.
  - go in any other state is ignored.
- LOAD:
  - in_ready=1. A beat is accepted when in_valid&&in_ready.
  - On an accepted beat in cycle t: z_out=in_data and z_valid_out=1 in cycle t+1 (one-cycle latency, registered).
  - z_valid_out=0 in cycles with no accepted beat; z_out holds its last value.
  - load_data_out=1 from the first cycle of LOAD through the cycle carrying word N-1 on z_out, then 0.
  - After the beat that accepts word N-1: in_ready drops the next cycle -> START.
  - Input bubbles are allowed; there is no upper limit on the gap between beats.
- START: sica_start_out=1 for exactly one cycle. This is the cycle after the last z_valid_out, so it never overlaps load_data_out. -> RUN; timeout counter tc=0.
- RUN:
  - sica_complete_in sampled high -> capture s_est_in into the internal register, then DRAIN with read index rc=0.
  - Otherwise tc++. When tc==TIMEOUT_CYCLES-1 without completion: timeout_err=1 and state -> IDLE, with no drain.
  - sica_complete_in is ignored outside RUN.
- DRAIN:
  - out_valid=1; out_data = capture[rc*DATA_WIDTH +: DATA_WIDTH]. Word order is identical to the input order.
  - out_data and out_valid are registered and stable while out_valid&&!out_ready.
  - On out_valid&&out_ready: rc++. When rc==N-1 is accepted, out_valid=0 the next cycle -> IDLE.
  - A simultaneous go in the last drain cycle is ignored; go is honoured from IDLE only.
- Counters never wrap. Comparisons are against N-1 exactly.
- Arithmetic: data passes through unchanged; there is no sign extension or rounding.

Decomposition:
- Package sica_pkg: state enum encoding (IDLE=0, LOAD=1, START=2, RUN=3, DRAIN=4) and localparam N_WORDS = DIM*SAMPLES helper. Also a default TIMEOUT constant shared with the system bench.
- One natural sub-module: sica_result_serializer. It holds the capture register and the rc read-index mux with the valid/ready output register. The FSM drives it through capture, start_drain and drain_done.

Test Plan:
- DIM=5, SAMPLES=10: go, then 50 back-to-back words 1..50 -> z_out reproduces 1..50 on 50 consecutive z_valid_out cycles, each one cycle after acceptance. load_data_out falls after word 50. sica_start_out pulses once, on the following cycle.
- Input with in_valid toggling 1,0,0,1... -> exactly 50 z_valid_out pulses in order. in_ready drops after word 50, and a 51st offered word is not accepted.
- Stub sica_top asserts complete 200 cycles after start, with s_est word k = -k. Hold out_ready=1 -> out_data sequence 0,-1,...,-49, then busy=0.
- Same as above but out_ready low for 3 cycles at word 7 -> out_data holds -7 with out_valid=1 for those cycles; no words are skipped or duplicated.
- TIMEOUT_CYCLES=100, complete never asserted -> timeout_err=1 at cycle 100 of RUN, state IDLE, out_valid never 1. The next go clears timeout_err.
- Assert reset in the middle of LOAD at word 23 -> the next cycle shows all outputs 0 and busy=0. A new go plus 50 words runs normally, and sica_start_out pulses only once.
